chunked_addsub: RTL

- Parametrised, multi-cycle add/subtract unit. It is the next generation of the processor's 32-bit two-stage carry-lookahead adder.
- Processes the operands CHUNK bits per cycle, holding the carry between cycles in a register.
- Supports add, add-with-carry-in and subtract, and reports carry, signed overflow and zero flags.
- Sits between decode/ALU control and writeback, with valid/ready handshakes on both sides.

---
 rtl/chunked_addsub.sv | 131 +++++++++++++
 1 files changed

// File: rtl/chunked_addsub.sv
// Multi-cycle add/subtract unit: walks the operands CHUNK bits per cycle,
// carrying between chunks in a register, and reports carry/overflow/zero.
// Valid/ready handshake on input and output; all outputs come from registers.
// WIDTH must be a multiple of CHUNK, and CHUNK >= 1.
module chunked_addsub #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CHUNK = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             sub,
   input  logic             c_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             carry,
   output logic             overflow,
   output logic             zero
);

   localparam int unsigned NCHUNK = WIDTH / CHUNK;
   localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e          state_q, state_d;
   logic [IDXW-1:0] idx_q, idx_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;       // already inverted for subtract
   logic [WIDTH-1:0] res_q, res_d;
   logic            cy_q, cy_d;      // inter-chunk carry
   logic            carry_q, carry_d;
   logic            ovf_q, ovf_d;
   logic            zero_q, zero_d;

   int unsigned      base;
   logic [CHUNK-1:0] a_ch, b_ch;
   logic [CHUNK:0]   ch_sum;
   logic [WIDTH-1:0] slot_mask;
   logic [WIDTH-1:0] res_merged;

   // Chunk datapath: add the current slice and merge it into the result word.
   always_comb begin
      base       = 32'(idx_q) * CHUNK;
      a_ch       = CHUNK'(a_q >> base);
      b_ch       = CHUNK'(b_q >> base);
      ch_sum     = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, cy_q};
      slot_mask  = WIDTH'({CHUNK{1'b1}}) << base;
      res_merged = (res_q & ~slot_mask) | (WIDTH'(ch_sum[CHUNK-1:0]) << base);
   end

   // Next-state logic for the IDLE -> RUN -> DONE sequence.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      cy_d    = cy_q;
      carry_d = carry_q;
      ovf_d   = ovf_q;
      zero_d  = zero_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               a_d     = in1;
               b_d     = sub ? ~in2 : in2;
               cy_d    = sub ? 1'b1 : c_in;
               idx_d   = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            res_d = res_merged;
            cy_d  = ch_sum[CHUNK];
            if (idx_q == LAST_IDX) begin
               carry_d = ch_sum[CHUNK];
               ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                         (res_merged[WIDTH-1] != a_q[WIDTH-1]);
               zero_d  = (res_merged == '0);
               state_d = StDone;
            end else begin
               idx_d = idx_q + IDXW'(1);
            end
         end
         StDone: begin
            // Retirement cycle never accepts a new operation.
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         cy_q    <= 1'b0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         cy_q    <= cy_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign out       = res_q;
   assign carry     = carry_q;
   assign overflow  = ovf_q;
   assign zero      = zero_q;

endmodule
